// File: rtl/apb_timer_pkg.sv
// apb_timer_pkg: shared widths, register offsets, bit positions and the responder FSM encoding.
package apb_timer_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned CNT_W      = 64;
  localparam int unsigned PRESCALE_W = 8;
  localparam int unsigned OFFS_W     = 5;

  localparam logic [OFFS_W-1:0] OFF_CTRL   = 5'h00;
  localparam logic [OFFS_W-1:0] OFF_STATUS = 5'h04;
  localparam logic [OFFS_W-1:0] OFF_CNT_LO = 5'h08;
  localparam logic [OFFS_W-1:0] OFF_CNT_HI = 5'h0C;
  localparam logic [OFFS_W-1:0] OFF_CMP_LO = 5'h10;
  localparam logic [OFFS_W-1:0] OFF_CMP_HI = 5'h14;

  localparam int unsigned CTRL_EN_BIT       = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT   = 1;
  localparam int unsigned CTRL_AUTO_CLR_BIT = 2;
  localparam int unsigned CTRL_PRESCALE_LSB = 8;
  localparam int unsigned STATUS_MATCH_BIT  = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_ACC  = 2'd1,
    RD_WAIT = 2'd2,
    RD_ACC  = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic [PRESCALE_W-1:0] prescale;
    logic                  auto_clr;
    logic                  irq_en;
    logic                  en;
  } ctrl_t;

  // True for word-aligned offsets that hit an implemented register.
  function automatic logic offset_mapped(input logic [OFFS_W-1:0] off);
    return (off[1:0] == 2'b00) && (off <= OFF_CMP_HI);
  endfunction

endpackage

// File: rtl/apb_timer_if.sv
// apb_timer_if: APB completer-side bus bundle for the system timer.
interface apb_timer_if #(
  parameter int unsigned APB_ADDR_WIDTH = 20
);
  logic                      PSEL;
  logic                      PENABLE;
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic                      PWRITE;
  logic [31:0]               PWDATA;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_timer_counter.sv
// apb_timer_counter: prescaler, 64-bit free-running counter, compare and software load path.
module apb_timer_counter
  import apb_timer_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  auto_clr_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic [CNT_W-1:0]      cmp_i,
  input  logic                  ld_lo_i,
  input  logic                  ld_hi_i,
  input  logic [DATA_W-1:0]     ld_data_i,
  output logic [CNT_W-1:0]      cnt_o,
  output logic                  match_pulse_o
);

  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  match_pulse_q, match_pulse_d;
  logic                  tick_c, hit_c;

  // Tick generation, count/compare update; a software load overrides any increment.
  always_comb begin
    tick_c        = en_i && (pre_cnt_q == prescale_i);
    hit_c         = (cnt_q == cmp_i);
    pre_cnt_d     = '0;
    cnt_d         = cnt_q;
    match_pulse_d = tick_c && hit_c;
    if (en_i && !tick_c) begin
      pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
    end
    if (tick_c) begin
      cnt_d = (hit_c && auto_clr_i) ? '0 : cnt_q + CNT_W'(1);
    end
    if (ld_lo_i) begin
      cnt_d = {cnt_q[CNT_W-1:DATA_W], ld_data_i};
    end
    if (ld_hi_i) begin
      cnt_d = {ld_data_i, cnt_q[DATA_W-1:0]};
    end
  end

  // Counter state flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_cnt_q     <= '0;
      cnt_q         <= '0;
      match_pulse_q <= 1'b0;
    end else begin
      pre_cnt_q     <= pre_cnt_d;
      cnt_q         <= cnt_d;
      match_pulse_q <= match_pulse_d;
    end
  end

  assign cnt_o         = cnt_q;
  assign match_pulse_o = match_pulse_q;

endmodule

// File: rtl/apb_timer.sv
// apb_timer: APB system timer with prescaled 64-bit counter, compare match flag and level IRQ.
// Build macro APB_TIMER_SLVERR_EN: flag unmapped or misaligned accesses with PSLVERR.
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH     = 32
) (
  input  logic       S_AXI_ACLK,
  input  logic       S_AXI_ARESETN,
  apb_timer_if.slave apb,
  output logic       irq_o
);

  apb_state_e            state_q, state_d;
  ctrl_t                 ctrl_q, ctrl_d;
  logic                  match_q, match_d;
  logic [CNT_W-1:0]      cmp_q, cmp_d;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_W-1:0]     shadow_q, shadow_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d, rdata_c;
  logic                  pready_q, pready_d;
  logic                  irq_q, irq_d;
  logic [OFFS_W-1:0]     offset_c;
  logic                  wr_en_c, ld_lo_c, ld_hi_c, match_pulse;
  logic                  unused_paddr_hi;

  // Upper address bits are already decoded by the bridge.
  assign offset_c        = apb.PADDR[OFFS_W-1:0];
  assign unused_paddr_hi = ^apb.PADDR[APB_ADDR_WIDTH-1:OFFS_W];
  assign wr_en_c         = (state_q == WR_ACC) && apb.PSEL && apb.PENABLE && apb.PWRITE;

  // FSM state register.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: writes take one access cycle, reads take a wait cycle then an access cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (apb.PSEL && !apb.PENABLE) begin
          state_d = apb.PWRITE ? WR_ACC : RD_WAIT;
        end
      end
      WR_ACC:  state_d = IDLE;
      RD_WAIT: state_d = RD_ACC;
      RD_ACC:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: PREADY low only while waiting, PRDATA captured from the mux in the wait cycle.
  always_comb begin
    pready_d = (state_d != RD_WAIT);
    prdata_d = prdata_q;
    if (state_q == RD_WAIT) begin
      prdata_d = rdata_c;
    end
  end

  // Register file updates, STATUS W1C (set wins), shadow capture on CNT_LO reads.
  always_comb begin
    ctrl_d   = ctrl_q;
    cmp_d    = cmp_q;
    match_d  = match_q;
    shadow_d = shadow_q;
    ld_lo_c  = 1'b0;
    ld_hi_c  = 1'b0;
    if (wr_en_c) begin
      case (offset_c)
        OFF_CTRL: begin
          ctrl_d.en       = apb.PWDATA[CTRL_EN_BIT];
          ctrl_d.irq_en   = apb.PWDATA[CTRL_IRQ_EN_BIT];
          ctrl_d.auto_clr = apb.PWDATA[CTRL_AUTO_CLR_BIT];
          ctrl_d.prescale = apb.PWDATA[CTRL_PRESCALE_LSB +: PRESCALE_W];
        end
        OFF_STATUS: begin
          if (apb.PWDATA[STATUS_MATCH_BIT]) begin
            match_d = 1'b0;
          end
        end
        OFF_CNT_LO: ld_lo_c = 1'b1;
        OFF_CNT_HI: ld_hi_c = 1'b1;
        OFF_CMP_LO: cmp_d[DATA_W-1:0] = apb.PWDATA;
        OFF_CMP_HI: cmp_d[CNT_W-1:DATA_W] = apb.PWDATA;
        default: ;
      endcase
    end
    if (match_pulse) begin
      match_d = 1'b1;
    end
    if ((state_q == RD_WAIT) && (offset_c == OFF_CNT_LO)) begin
      shadow_d = cnt[CNT_W-1:DATA_W];
    end
    irq_d = match_d & ctrl_d.irq_en;
  end

  // Read mux; unmapped and misaligned offsets read as zero.
  always_comb begin
    rdata_c = '0;
    case (offset_c)
      OFF_CTRL: begin
        rdata_c[CTRL_EN_BIT]                        = ctrl_q.en;
        rdata_c[CTRL_IRQ_EN_BIT]                    = ctrl_q.irq_en;
        rdata_c[CTRL_AUTO_CLR_BIT]                  = ctrl_q.auto_clr;
        rdata_c[CTRL_PRESCALE_LSB +: PRESCALE_W]    = ctrl_q.prescale;
      end
      OFF_STATUS: rdata_c[STATUS_MATCH_BIT] = match_q;
      OFF_CNT_LO: rdata_c = cnt[DATA_W-1:0];
      OFF_CNT_HI: rdata_c = shadow_q;
      OFF_CMP_LO: rdata_c = cmp_q[DATA_W-1:0];
      OFF_CMP_HI: rdata_c = cmp_q[CNT_W-1:DATA_W];
      default: ;
    endcase
  end

  // Register file and registered bus outputs.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ctrl_q   <= '0;
      match_q  <= 1'b0;
      cmp_q    <= '0;
      shadow_q <= '0;
      prdata_q <= '0;
      pready_q <= 1'b1;
      irq_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      match_q  <= match_d;
      cmp_q    <= cmp_d;
      shadow_q <= shadow_d;
      prdata_q <= prdata_d;
      pready_q <= pready_d;
      irq_q    <= irq_d;
    end
  end

`ifdef APB_TIMER_SLVERR_EN
  logic pslverr_q, pslverr_d;

  // Error flag presented in the PREADY=1 cycle of a bad access.
  always_comb begin
    pslverr_d = ((state_d == WR_ACC) || (state_d == RD_ACC)) && !offset_mapped(offset_c);
  end

  // Error response flop.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      pslverr_q <= 1'b0;
    end else begin
      pslverr_q <= pslverr_d;
    end
  end

  assign apb.PSLVERR = pslverr_q;
`else
  assign apb.PSLVERR = 1'b0;
`endif

  assign apb.PRDATA = prdata_q;
  assign apb.PREADY = pready_q;
  assign irq_o      = irq_q;

  apb_timer_counter u_counter (
    .clk_i         (S_AXI_ACLK),
    .rst_ni        (S_AXI_ARESETN),
    .en_i          (ctrl_q.en),
    .auto_clr_i    (ctrl_q.auto_clr),
    .prescale_i    (ctrl_q.prescale),
    .cmp_i         (cmp_q),
    .ld_lo_i       (ld_lo_c),
    .ld_hi_i       (ld_hi_c),
    .ld_data_i     (apb.PWDATA),
    .cnt_o         (cnt),
    .match_pulse_o (match_pulse)
  );

endmodule
